// File: rtl/core_defines_pkg.sv
// Shared core constants for the instruction fetch path.
//   XLEN             : architectural register/address width
//   INST_NOP         : canonical NOP (addi x0, x0, 0) shown when no instruction is held
//   RESET_PC_DEFAULT : default first fetch address after reset
package core_defines;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous in-order queue with a registered head.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of all entries (wins over push/pop)
//   push       : write push_data at the tail (ignored when full and not popping)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head entry, straight from storage registers
//   full/empty : occupancy flags
//   count      : number of valid entries
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    rd_ptr;
    logic [IW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign count     = cnt;
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Data storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch unit between the fetch stage and a variable-latency
// instruction memory.
//   clk, rst_n     : clock, asynchronous active-low reset
//   jump_en_i      : redirect; flushes the queue, fetch restarts at jump_addr_i
//   jump_addr_i    : redirect target (low two bits ignored)
//   inst_ready_i   : fetch stage takes the head instruction this cycle
//   inst_valid_o   : head instruction valid
//   inst_o         : head instruction, NOP when empty
//   inst_addr_o    : head instruction address, 0 when empty
//   mem_req_o      : fetch request, mem_addr_o : word-aligned fetch address
//   mem_gnt_i      : request accepted, mem_rvalid_i/mem_rdata_i : in-order read data
//
// Handshakes: an instruction transfers on a cycle where inst_valid_o and
// inst_ready_i are both high; a memory request transfers on a cycle where
// mem_req_o and mem_gnt_i are both high. mem_req_o may drop before grant.
module ifetch_prefetch
    import core_defines::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            inst_ready_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   out_next;
    logic [CW-1:0]   discard;
    logic [CW:0]     credits_used;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_addr;
    logic [XLEN-1:0] jump_target;
    logic [63:0]     head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            req_acc;
    logic            rsp;
    logic            push;
    logic            pop;

    // Every granted request owns a queue slot until its data is popped or
    // dropped, so the queue can never overflow. Stale (to-be-discarded)
    // requests hold credits too, since their responses still arrive.
    assign credits_used = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_o    = rst_n && !jump_en_i && (credits_used < (CW+1)'(DEPTH));
    assign mem_addr_o   = fetch_pc;
    assign req_acc      = mem_req_o && mem_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp          = mem_rvalid_i && (outstanding != '0);
    assign out_next     = outstanding + CW'(req_acc) - CW'(rsp);
    assign push         = rsp && (discard == '0) && !jump_en_i && (!fifo_full || pop);
    assign pop          = inst_valid_o && inst_ready_i;
    assign jump_target  = {jump_addr_i[XLEN-1:2], 2'b00};

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? INST_NOP : head[31:0];
    assign inst_addr_o  = fifo_empty ? '0 : head[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            resp_addr   <= RESET_PC;
        end else begin
            outstanding <= out_next;
            if (jump_en_i) begin
                // No request issues in a jump cycle, and a response arriving now
                // is dropped, so out_next counts exactly the stale requests left.
                discard   <= out_next;
                fetch_pc  <= jump_target;
                resp_addr <= jump_target;
            end else begin
                if (req_acc) fetch_pc <= fetch_pc + 32'd4;
                if (rsp) begin
                    if (discard != '0) discard   <= discard - CW'(1);
                    else               resp_addr <= resp_addr + 32'd4;
                end
            end
        end
    end

    fifo_sync #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (jump_en_i),
        .push      (push),
        .push_data ({resp_addr, mem_rdata_i}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: memory responder, transaction-level reference
// model (held addresses plus epoch-tagged outstanding requests), a directed
// vector table and hand-written corner sequences.
module tb_ifetch_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        inst_ready_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .inst_ready_i (inst_ready_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    // ---------------- bench state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic        ready;
        logic        req;
        logic [31:0] maddr;
        logic        valid;
        logic [31:0] iaddr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int epoch = 0;
    int grant_cnt = 0;

    pend_t       pending[$];   // granted, response not yet returned
    logic [31:0] exp_q[$];     // addresses expected in the DUT queue, head first
    logic [31:0] gq[$];        // granted addresses, in order
    logic [31:0] dlv[$];       // delivered addresses, in order
    logic [31:0] next_fetch = '0;
    logic [31:0] next_deliver = '0;

    // stimulus controls
    int          gnt_mode = 1;  // 0 random, 1 always, 2 never
    int          lat = 1;
    logic        lat_rand = 1'b0;
    logic        rv_rand = 1'b0;
    logic        rv_en = 1'b1;
    logic        spurious = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jtarget = '0;
    logic        ready = 1'b1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver + reference model, one clock per call ----------------
    task automatic step();
        logic        rv;
        logic        exp_req;
        logic        popped;
        pend_t       r;
        @(posedge clk);
        #1;
        cyc++;
        rv = (pending.size() > 0) && (pending[0].due <= cyc) && rv_en &&
             (!rv_rand || ($urandom_range(0, 1) == 1));
        mem_rvalid_i = rv || (spurious && pending.size() == 0);
        mem_rdata_i  = rv ? mem_data(pending[0].addr) : $urandom;
        case (gnt_mode)
            1:       mem_gnt_i = 1'b1;
            2:       mem_gnt_i = 1'b0;
            default: mem_gnt_i = ($urandom_range(0, 2) != 0);
        endcase
        jump_en_i    = jump;
        jump_addr_i  = jtarget;
        inst_ready_i = ready;
        #1;
        // compare against the model state for this cycle
        exp_req = !jump && ((exp_q.size() + pending.size()) < DEPTH);
        chk("mem_req", 32'(mem_req_o), 32'(exp_req));
        chk("inst_valid", 32'(inst_valid_o), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("inst_addr", inst_addr_o, exp_q[0]);
            chk("inst_data", inst_o, mem_data(exp_q[0]));
        end else begin
            chk("inst_nop", inst_o, NOP);
            chk("inst_addr_empty", inst_addr_o, 32'h0);
        end
        // model update for the coming edge
        popped = inst_valid_o && inst_ready_i && !jump;
        if (popped) begin
            chk("order", inst_addr_o, next_deliver);
            next_deliver += 32'd4;
            dlv.push_back(inst_addr_o);
            void'(exp_q.pop_front());
        end
        if (rv) begin
            r = pending.pop_front();
            if (r.epoch == epoch && !jump) exp_q.push_back(r.addr);
        end
        if (jump) begin
            exp_q.delete();
            epoch++;
            next_fetch   = {jtarget[31:2], 2'b00};
            next_deliver = next_fetch;
        end
        if (mem_req_o && mem_gnt_i) begin
            chk("mem_addr", mem_addr_o, next_fetch);
            gq.push_back(mem_addr_o);
            grant_cnt++;
            pending.push_back('{addr: mem_addr_o, epoch: epoch,
                                due: cyc + (lat_rand ? $urandom_range(1, 3) : lat)});
            next_fetch += 32'd4;
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must change without a clock.
    task automatic do_reset();
        jump_en_i    = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        jump         = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, 32'h0);
        chk("rst_req", 32'(mem_req_o), 32'h0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pending.delete();
        exp_q.delete();
        gq.delete();
        dlv.delete();
        epoch++;
        grant_cnt    = 0;
        next_fetch   = '0;
        next_deliver = '0;
        cyc          = 0;
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[9];
    int   n;

    initial begin
        // Directed table: gnt always, rvalid 1 cycle after gnt, ready high.
        // Row 5 jumps to 0x203 while the response for 0x10 returns.
        tbl[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h000, 1'b0, 32'h000};
        tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h004, 1'b0, 32'h000};
        tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h008, 1'b1, 32'h000};
        tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h00C, 1'b1, 32'h004};
        tbl[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h008};
        tbl[5] = '{1'b1, 32'h203, 1'b1, 1'b0, 32'h014, 1'b1, 32'h00C};
        tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h000};
        tbl[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h000};
        tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200};

        #3;
        do_reset();

        // Tests 1, 4, 5: table
        gnt_mode = 1; lat = 1; lat_rand = 1'b0; rv_rand = 1'b0;
        for (int i = 0; i < 9; i++) begin
            jump    = tbl[i].jump;
            jtarget = tbl[i].jaddr;
            ready   = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d_req", i), 32'(mem_req_o), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_maddr", i), mem_addr_o, tbl[i].maddr);
            chk($sformatf("tbl%0d_valid", i), 32'(inst_valid_o), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_iaddr", i), inst_addr_o, tbl[i].iaddr);
            chk($sformatf("tbl%0d_inst", i), inst_o,
                tbl[i].valid ? mem_data(tbl[i].iaddr) : NOP);
        end
        jump = 1'b0;

        // Test 2: back-pressure fills exactly DEPTH credits, nothing lost
        do_reset();
        ready = 1'b0;
        repeat (10) step();
        chk("t2_grants", 32'(grant_cnt), 32'(DEPTH));
        chk("t2_req_low", 32'(mem_req_o), 32'h0);
        ready = 1'b1;
        n = 0;
        while (dlv.size() < 5 && n < 30) begin step(); n++; end
        chk("t2_wait", 32'(dlv.size() >= 5), 32'h1);
        if (dlv.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk($sformatf("t2_dlv%0d", i), dlv[i], 32'(i * 4));
        end
        chk("t2_resume", (gq.size() > 4) ? gq[4] : 32'hFFFF_FFFF, 32'h10);

        // Test 3: jump with 8 and 12 outstanding; both responses dropped
        do_reset();
        lat = 5; gnt_mode = 1;
        n = 0;
        while (grant_cnt < 4 && n < 20) begin step(); n++; end
        gnt_mode = 2;
        n = 0;
        while (pending.size() > 2 && n < 20) begin step(); n++; end
        chk("t3_wait_out", 32'(pending.size()), 32'h2);
        jump = 1'b1; jtarget = 32'h100; rv_en = 1'b0;
        step();
        jump = 1'b0; rv_en = 1'b1; gnt_mode = 1; lat = 1;
        dlv.delete();
        n = 0;
        while (dlv.size() < 2 && n < 40) begin step(); n++; end
        chk("t3_wait", 32'(dlv.size() >= 2), 32'h1);
        chk("t3_first", (dlv.size() > 0) ? dlv[0] : 32'hFFFF_FFFF, 32'h100);
        chk("t3_second", (dlv.size() > 1) ? dlv[1] : 32'hFFFF_FFFF, 32'h104);

        // Spurious rvalid with nothing outstanding must be ignored
        do_reset();
        gnt_mode = 2; spurious = 1'b1;
        repeat (3) step();
        chk("spur_valid", 32'(inst_valid_o), 32'h0);
        spurious = 1'b0;

        // Test 6: random stalls, ready and jumps, with a reset mid-stream
        gnt_mode = 0; lat_rand = 1'b1; rv_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            ready    = ($urandom_range(0, 3) != 0);
            jump     = ($urandom_range(0, 29) == 0);
            jtarget  = $urandom;
            spurious = ($urandom_range(0, 9) == 0);
            step();
            if (i == 400) do_reset();
        end
        jump = 1'b0;
        spurious = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
